mem_line_transfer_ctrl: RTL
===========================

// Module: mem_line_transfer_ctrl
// PURPOSE
//   Initiator side of the word-addressed synchronous memory port (address, data_in,
//   write_enable, data_out; 1-cycle registered read). Accepts one whole-line read or
//   write request from the cache. Converts it into WORDS_PER_LINE consecutive word
//   accesses. Returns the assembled line with a one-cycle completion pulse.
// PARAMETERS
//   WORDS_PER_LINE  4   words per cache line; power of two, >=2
//   ADDR_WIDTH      32  word-address width presented to memory
//   DATA_WIDTH      32  memory word width
// PORTS
//   clk               in   1                        rising-edge clock
//   reset             in   1                        synchronous, active-high
//   req_valid         in   1                        cache request present
//   req_write         in   1                        1 = write line, 0 = read line
//   req_addr          in   ADDR_WIDTH               word address; low log2(WPL) bits ignored
//   req_wdata         in   DATA_WIDTH*WPL           line to write; word i = bits [i*DW +: DW]
//   req_ready         out  1                        controller can accept (IDLE only)
//   resp_valid        out  1                        one-cycle completion pulse
//   resp_rdata        out  DATA_WIDTH*WPL           last line read; word i = bits [i*DW +: DW]
//   mem_address       out  ADDR_WIDTH               word address to memory
//   mem_data_in       out  DATA_WIDTH               write data to memory
//   mem_write_enable  out  1                        memory write strobe
//   mem_data_out      in   DATA_WIDTH               memory read data, valid 1 edge after address
// BEHAVIOUR
//   States: IDLE, WRITE, READ, DRAIN, RESP. Word counter cnt is 0..WPL-1.
//   Reset: state=IDLE, cnt=0, base=0, captured write line=0, resp_rdata=0.
//     Resulting outputs: req_ready=1, resp_valid=0, mem_write_enable=0,
//     mem_address=0, mem_data_in=0.
//   Accept: on edge with state==IDLE && req_valid.
//     base = req_addr with low log2(WPL) bits cleared; latch req_wdata; cnt=0.
//     Next state: WRITE if req_write, else READ.
//   Combinational outputs:
//     mem_address = base + cnt; low bits replace, no carry; never crosses the line.
//     mem_data_in = latched word[cnt].
//     mem_write_enable = (state==WRITE) && !reset.
//     req_ready = (state==IDLE).
//     resp_valid = (state==RESP).
//   WRITE: one word commits per edge.
//     cnt++ each cycle; after the cnt==WPL-1 cycle -> RESP.
//     Latency: accept edge + WPL write cycles + 1 RESP cycle.
//   READ: issues one address per cycle, cnt=0..WPL-1, with mem_write_enable=0.
//     Memory registers data at the issuing edge.
//     The controller samples mem_data_out on the following edge into resp_rdata word cnt-1.
//     After cnt==WPL-1 -> DRAIN.
//   DRAIN: captures word WPL-1 -> RESP. No memory access is meaningful.
//     Read latency: accept edge + WPL + 1 cycles before RESP.
//   RESP: held exactly 1 cycle with resp_valid=1 and req_ready=0 -> IDLE.
//     No backpressure: the cache must consume resp_rdata during the RESP cycle.
//     resp_rdata holds afterwards until the next read's words overwrite it.
//   Writes never modify resp_rdata.
//   Requests while busy are ignored (req_ready=0); the requester holds req_valid.
//     Minimum gap between accepts is one IDLE cycle after RESP.
//   Latched line and base are stable for the whole transfer.
//     Changes on req_* after accept have no effect.
//   Reset mid-operation: the reset edge commits no write (enable gated by reset).
//     State goes to IDLE with no resp_valid. Words written before that edge stay in memory.
//     A partially read line in resp_rdata is cleared to 0.
//   Top-of-space line (base = all-ones & ~(WPL-1)) wraps nowhere; the last word is all-ones.
// TESTING
//   1. Write 0x40 line {0x11,0x22,0x33,0x44}, then read 0x40:
//      - mem receives writes at 0x40..0x43 on 4 consecutive edges.
//      - resp_valid 5 cycles after write accept.
//      - read resp_rdata = 0x44_33_22_11 word order, resp_valid 6 cycles after read accept.
//   2. Read req_addr=0x43: mem_address sequence 0x40,0x41,0x42,0x43.
//      - write_enable stays 0 throughout; line returned matches memory contents.
//   3. Reset asserted during the 3rd write cycle:
//      - only 0x40,0x41 change; 0x42/0x43 keep old values.
//      - resp_valid never pulses; req_ready=1 after the reset edge.
//   4. req_valid held with a new address during a read:
//      - ignored until IDLE, then accepted exactly once.
//      - first response unchanged.
//   5. Back-to-back: read immediately after write RESP:
//      - read accepted on the IDLE cycle following RESP.
//      - resp_rdata unchanged by the write.
//   6. WPL=8, read at line base 0xFFFFFFF8: addresses 0xFFFFFFF8..0xFFFFFFFF.
//      - no overflow to 0.
//      - resp_valid after 10 cycles.

Source files
------------

// File: rtl/mem_line_transfer_ctrl_if.sv
// mem_line_transfer_ctrl_if
//   Bundles the cache-side request/response handshake and the word-wide
//   synchronous memory port of the line transfer controller.
//   Modports:
//     master - the transfer controller: takes requests, issues memory accesses
//     slave  - the environment: cache requester plus the memory itself
//   Signals:
//     req_valid/req_write/req_addr/req_wdata  cache request (line write data
//                                              word i at [i*DW +: DW])
//     req_ready                               controller idle, can accept
//     resp_valid/resp_rdata                   one-cycle completion, last read line
//     mem_address/mem_data_in/mem_write_enable  word access to memory
//     mem_data_out                            memory read data, one edge after address
interface mem_line_transfer_ctrl_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
);
    logic                                 req_valid;
    logic                                 req_write;
    logic [ADDR_WIDTH-1:0]                req_addr;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_wdata;
    logic                                 req_ready;
    logic                                 resp_valid;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] resp_rdata;
    logic [ADDR_WIDTH-1:0]                mem_address;
    logic [DATA_WIDTH-1:0]                mem_data_in;
    logic                                 mem_write_enable;
    logic [DATA_WIDTH-1:0]                mem_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata,
               mem_address, mem_data_in, mem_write_enable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata,
               mem_address, mem_data_in, mem_write_enable
    );
endinterface

// File: rtl/mem_line_transfer_ctrl.sv
// mem_line_transfer_ctrl
//   Initiator side of a word-addressed synchronous memory with a one-cycle
//   registered read. Takes one whole-line read or write request from the
//   cache, turns it into WORDS_PER_LINE consecutive word accesses inside the
//   line, and finishes with a single-cycle resp_valid pulse. A read line is
//   returned on resp_rdata and held there until the next read replaces it.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    mem_line_transfer_ctrl_if.master (request, response, memory port)
module mem_line_transfer_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_line_transfer_ctrl_if.master  bus
);
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } state_t;

    state_t                       state;
    logic [IDX_W-1:0]             cnt;
    logic [IDX_W-1:0]             prev_idx;
    logic [ADDR_WIDTH-IDX_W-1:0]  line_addr;
    logic [LINE_W-1:0]            wr_line;
    logic [LINE_W-1:0]            rd_line;
    logic                         ready_q;
    logic                         resp_q;
    logic                         write_q;

    // The word offset inside a line comes from the counter, never from the request.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[IDX_W-1:0];

    // Read data arrives one edge after its address, so it belongs to the previous word.
    assign prev_idx = cnt - 1'b1;

    // Control FSM: walks the words of a line, assembles read data and keeps
    // the handshake flags registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            line_addr <= '0;
            wr_line   <= '0;
            rd_line   <= '0;
            ready_q   <= 1'b1;
            resp_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        line_addr <= bus.req_addr[ADDR_WIDTH-1:IDX_W];
                        wr_line   <= bus.req_wdata;
                        cnt       <= '0;
                        ready_q   <= 1'b0;
                        if (bus.req_write) begin
                            state   <= WRITE;
                            write_q <= 1'b1;
                        end else begin
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state   <= RESP;
                        write_q <= 1'b0;
                        resp_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        rd_line[int'(prev_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data_out;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rd_line[int'(LAST_IDX)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data_out;
                    state  <= RESP;
                    resp_q <= 1'b1;
                end
                RESP: begin
                    state   <= IDLE;
                    resp_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    resp_q  <= 1'b0;
                    ready_q <= 1'b1;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    // The counter replaces the low address bits, so a line never carries into
    // the next one, including the top line of the address space.
    assign bus.mem_address      = {line_addr, cnt};
    assign bus.mem_data_in      = wr_line[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];
    // Gating with reset keeps the reset edge itself from committing a word.
    assign bus.mem_write_enable = write_q && !reset;
    assign bus.req_ready        = ready_q;
    assign bus.resp_valid       = resp_q;
    assign bus.resp_rdata       = rd_line;
endmodule
